// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: op codes, selector encodings,
// the registered ALU request record and the output/skid occupancy state.
package alu_pkg;

    localparam int DW   = 32;
    localparam int IMMW = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_NOR  = 3'd1,
        OP_NORI = 3'd2,
        OP_NOT  = 3'd3,
        OP_BLEU = 3'd4,
        OP_ROLV = 3'd5,
        OP_RORV = 3'd6
    } op_e;

    localparam logic [4:0] SEL_ADD  = 5'b10000;
    localparam logic [4:0] SEL_NOR  = 5'b10011;
    localparam logic [4:0] SEL_NORI = 5'b00111;
    localparam logic [4:0] SEL_NOT  = 5'b00010;
    localparam logic [4:0] SEL_BLEU = 5'b01000;
    localparam logic [4:0] SEL_ROLV = 5'b00000;
    localparam logic [4:0] SEL_RORV = 5'b00001;

    typedef struct packed {
        logic [DW-1:0] i1;
        logic [DW-1:0] i2;
        logic [4:0]    sel;
        logic [4:0]    rd;
    } alu_req_t;

    // Idle value presented to the ALU after reset: zero operands, ADD selector.
    localparam alu_req_t REQ_RESET = '{i1: '0, i2: '0, sel: SEL_ADD, rd: '0};

    // EMPTY: nothing held; ONE: output reg full; TWO: output and skid regs full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/alu_issue_if.sv
// Decode-to-ALU handshake bundle: decode-side request channel and ALU-side operand channel.
// slave is the issue stage's view, master is the view of whoever drives decode and consumes ops.
interface alu_issue_if #(parameter int CNTW = 32);
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    op_e               in_op;
    logic [DW-1:0]     in_rs;
    logic [DW-1:0]     in_rt;
    logic [IMMW-1:0]   in_imm;
    logic [4:0]        in_rd;

    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     alu_i1;
    logic [DW-1:0]     alu_i2;
    logic [4:0]        alu_sel;
    logic [4:0]        out_rd;
    logic              illegal_op;
    logic [CNTW-1:0]   issued_cnt;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_imm, in_rd, out_ready,
        output in_ready, out_valid, alu_i1, alu_i2, alu_sel, out_rd, illegal_op, issued_cnt
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_imm, in_rd, out_ready,
        input  in_ready, out_valid, alu_i1, alu_i2, alu_sel, out_rd, illegal_op, issued_cnt
    );

endinterface

// File: rtl/alu_operand_mux.sv
// Combinational operand former: maps an op code plus rs/rt/imm onto ALU I1/I2/Selector
// and flags op codes with no ALU mapping.
module alu_operand_mux
    import alu_pkg::*;
(
    input  op_e             op,
    input  logic [DW-1:0]   rs,
    input  logic [DW-1:0]   rt,
    input  logic [IMMW-1:0] imm,
    input  logic [4:0]      rd,
    output alu_req_t        req,
    output logic            illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        req     = REQ_RESET;
        req.rd  = rd;
        illegal = 1'b0;
        case (op)
            OP_ADD:  begin req.i1 = rs; req.i2 = rt; req.sel = SEL_ADD;  end
            OP_NOR:  begin req.i1 = rs; req.i2 = rt; req.sel = SEL_NOR;  end
            OP_NORI: begin req.i1 = rs; req.i2 = {{(DW-IMMW){1'b0}}, imm}; req.sel = SEL_NORI; end
            OP_NOT:  begin req.i1 = rs; req.i2 = '0; req.sel = SEL_NOT;  end
            OP_BLEU: begin req.i1 = rs; req.i2 = rt; req.sel = SEL_BLEU; end
            // Rotates take the value from rt and the rotate amount from the low bits of rs.
            OP_ROLV: begin req.i1 = rt; req.i2 = {{(DW-5){1'b0}}, rs[4:0]}; req.sel = SEL_ROLV; end
            OP_RORV: begin req.i1 = rt; req.i2 = {{(DW-5){1'b0}}, rs[4:0]}; req.sel = SEL_RORV; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: registered operand/selector output with a one-entry skid register behind it,
// giving full throughput under back-pressure; drops illegal ops and counts issued ops.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int CNTW = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_issue_if.slave bus
);

    alu_req_t        req;
    logic            illegal;
    alu_req_t        o_q;
    alu_req_t        s_q;
    occ_e            state;
    occ_e            state_next;
    logic            in_ready_q;
    logic            illegal_q;
    logic [CNTW-1:0] cnt_q;

    logic            out_valid;
    logic            drain;
    logic            push;
    logic            o_load_new;
    logic            o_load_skid;
    logic            s_load;

    alu_operand_mux u_mux (
        .op      (bus.in_op),
        .rs      (bus.in_rs),
        .rt      (bus.in_rt),
        .imm     (bus.in_imm),
        .rd      (bus.in_rd),
        .req     (req),
        .illegal (illegal)
    );

    assign drain = out_valid & bus.out_ready;
    // Illegal ops complete the handshake but never take a buffer slot.
    assign push  = bus.in_valid & in_ready_q & ~illegal;

    // in_ready is registered from the next occupancy so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != ST_TWO);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (push) state_next = ST_ONE;
            ST_ONE: begin
                if (push && !drain)      state_next = ST_TWO;
                else if (!push && drain) state_next = ST_EMPTY;
            end
            ST_TWO:   if (drain) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid   = (state != ST_EMPTY);
        o_load_new  = push & ((state == ST_EMPTY) | ((state == ST_ONE) & bus.out_ready));
        o_load_skid = (state == ST_TWO) & bus.out_ready;
        s_load      = push & (state == ST_ONE) & ~bus.out_ready;
    end

    always_ff @(posedge clk) begin
        // NOTE: the two data registers are reset too, so the ALU sees a defined idle op after reset.
        if (!rst_n) begin
            o_q       <= REQ_RESET;
            s_q       <= REQ_RESET;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (o_load_skid)     o_q <= s_q;
            else if (o_load_new) o_q <= req;
            if (s_load)          s_q <= req;
            illegal_q <= bus.in_valid & in_ready_q & illegal;
            if (drain)           cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid;
    assign bus.alu_i1     = o_q.i1;
    assign bus.alu_i2     = o_q.i2;
    assign bus.alu_sel    = o_q.sel;
    assign bus.out_rd     = o_q.rd;
    assign bus.illegal_op = illegal_q;
    assign bus.issued_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a negedge scoreboard monitor plus one task per scenario.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if #(.CNTW(32)) bus ();

    alu_issue_stage #(.CNTW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp     = 0;
    int          n_err     = 0;
    int          n_drained = 0;
    logic [31:0] model_cnt = '0;
    alu_req_t    sb[$];
    bit          mon_en     = 1'b0;
    bit          exp_ill    = 1'b0;
    bit          prev_stall = 1'b0;
    alu_req_t    snap;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [31:0] ei1;
        logic [31:0] ei2;
        logic [4:0]  esel;
    } map_vec_t;

    function automatic alu_req_t model(input logic [2:0] op, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [15:0] imm,
                                       input logic [4:0] rd);
        alu_req_t r;
        r.rd = rd;
        case (op)
            3'd0:    begin r.i1 = rs; r.i2 = rt;               r.sel = 5'b10000; end
            3'd1:    begin r.i1 = rs; r.i2 = rt;               r.sel = 5'b10011; end
            3'd2:    begin r.i1 = rs; r.i2 = {16'h0000, imm};  r.sel = 5'b00111; end
            3'd3:    begin r.i1 = rs; r.i2 = 32'h0;            r.sel = 5'b00010; end
            3'd4:    begin r.i1 = rs; r.i2 = rt;               r.sel = 5'b01000; end
            3'd5:    begin r.i1 = rt; r.i2 = {27'h0, rs[4:0]}; r.sel = 5'b00000; end
            default: begin r.i1 = rt; r.i2 = {27'h0, rs[4:0]}; r.sel = 5'b00001; end
        endcase
        return r;
    endfunction

    // Scoreboard monitor: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin : monitor
        alu_req_t got;
        alu_req_t exp;
        bit       acc;
        bit       is_ill;
        if (mon_en) begin
            got = '{i1: bus.alu_i1, i2: bus.alu_i2, sel: bus.alu_sel, rd: bus.out_rd};
            n_cmp++;
            if (bus.illegal_op !== exp_ill) begin
                n_err++;
                $display("FAIL illegal_pulse t=%0t got=%b exp=%b", $time, bus.illegal_op, exp_ill);
            end
            if (prev_stall) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || got !== snap) begin
                    n_err++;
                    $display("FAIL stall_stable t=%0t got=%h exp=%h valid=%b", $time, got, snap, bus.out_valid);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output t=%0t got=%h exp=none", $time, got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL output_order t=%0t got=%h exp=%h", $time, got, exp);
                    end
                end
                n_drained++;
                model_cnt++;
            end
            acc    = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
            is_ill = (3'(bus.in_op) == 3'd7);
            exp_ill = acc && is_ill;
            if (acc && !is_ill)
                sb.push_back(model(3'(bus.in_op), bus.in_rs, bus.in_rt, bus.in_imm, bus.in_rd));
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            snap = got;
        end
    end

    task automatic set_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] imm, input logic [4:0] rd);
        bus.in_op  = op_e'(op);
        bus.in_rs  = rs;
        bus.in_rt  = rt;
        bus.in_imm = imm;
        bus.in_rd  = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds rst_n low for the given edges; the monitor's model state is cleared alongside.
    task automatic hold_reset(input int cycles);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        repeat (cycles) tick();
        sb.delete();
        model_cnt  = '0;
        exp_ill    = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic release_reset();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        set_op(3'd0, 32'h1111_1111, 32'h2222_2222, 16'h0, 5'd9);
        hold_reset(3);
        n_cmp++; if (bus.out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0)   begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        n_cmp++; if (bus.issued_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", bus.issued_cnt); end
        n_cmp++; if (bus.alu_sel !== 5'b10000) begin n_err++; $display("FAIL rst_sel got=%b exp=10000", bus.alu_sel); end
        n_cmp++; if (bus.alu_i1 !== 32'h0 || bus.alu_i2 !== 32'h0 || bus.out_rd !== 5'd0) begin
            n_err++; $display("FAIL rst_fields got=%h/%h/%h exp=0/0/0", bus.alu_i1, bus.alu_i2, bus.out_rd);
        end
        n_cmp++; if (bus.illegal_op !== 1'b0) begin n_err++; $display("FAIL rst_illegal got=%b exp=0", bus.illegal_op); end
        bus.in_valid = 1'b0;
        release_reset();
        n_cmp++; if (bus.in_ready !== 1'b1)  begin n_err++; $display("FAIL rst_release_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_release_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_map();
        map_vec_t vecs[3];
        vecs[0] = '{op: 3'd2, rs: 32'h0000_F0F0, rt: 32'hDEAD_BEEF, imm: 16'h00FF,
                    ei1: 32'h0000_F0F0, ei2: 32'h0000_00FF, esel: 5'b00111};
        vecs[1] = '{op: 3'd6, rs: 32'h0000_0023, rt: 32'h8000_0001, imm: 16'hFFFF,
                    ei1: 32'h8000_0001, ei2: 32'h0000_0003, esel: 5'b00001};
        vecs[2] = '{op: 3'd3, rs: 32'h1234_5678, rt: 32'hFFFF_FFFF, imm: 16'h1234,
                    ei1: 32'h1234_5678, ei2: 32'h0000_0000, esel: 5'b00010};
        for (int v = 0; v < 3; v++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            set_op(vecs[v].op, vecs[v].rs, vecs[v].rt, vecs[v].imm, 5'(v + 1));
            tick();
            bus.in_valid = 1'b0;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.alu_i1 !== vecs[v].ei1 || bus.alu_i2 !== vecs[v].ei2 ||
                bus.alu_sel !== vecs[v].esel) begin
                n_err++;
                $display("FAIL map_%0d got=%b %h %h %b exp=1 %h %h %b", v, bus.out_valid, bus.alu_i1,
                         bus.alu_i2, bus.alu_sel, vecs[v].ei1, vecs[v].ei2, vecs[v].esel);
            end
            bus.out_ready = 1'b1;
            tick();
        end
        // Random legal ops under random valid/ready, checked by the scoreboard.
        for (int c = 0; c < 60; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            set_op(3'($urandom_range(0, 6)), $urandom, $urandom, 16'($urandom), 5'($urandom));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL map_drain got=%0d pending valid=%b exp=0 pending", sb.size(), bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int  sent = 0;
        int  base;
        bit  acc;
        hold_reset(1);
        bus.in_valid = 1'b0;
        release_reset();
        base = n_drained;
        for (int c = 0; c < 16; c++) begin
            bus.out_ready = !(c >= 2 && c <= 4);
            bus.in_valid  = (sent < 6);
            set_op(3'd0, 32'h100 + 32'(sent), 32'(sent), 16'h0, 5'(sent));
            if (c == 2) begin
                n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_c2 got=%b exp=1", bus.in_ready); end
            end
            if (c == 3 || c == 4) begin
                n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_c%0d got=%b exp=0", c, bus.in_ready); end
            end
            acc = bus.in_valid && (bus.in_ready === 1'b1);
            tick();
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (n_drained - base != 6) begin n_err++; $display("FAIL bp_delivered got=%0d exp=6", n_drained - base); end
        n_cmp++; if (bus.issued_cnt !== 32'd6) begin n_err++; $display("FAIL bp_cnt got=%0d exp=6", bus.issued_cnt); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL bp_pending got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_full_rate();
        int base = n_drained;
        int bubbles = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c <= 100; c++) begin
            bus.in_valid = (c < 100);
            set_op(3'($urandom_range(0, 6)), $urandom, $urandom, 16'($urandom), 5'($urandom));
            if (c >= 1 && bus.out_valid !== 1'b1) bubbles++;
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bubbles != 0) begin n_err++; $display("FAIL full_rate_bubbles got=%0d exp=0", bubbles); end
        n_cmp++; if (n_drained - base != 100) begin n_err++; $display("FAIL full_rate_count got=%0d exp=100", n_drained - base); end
        n_cmp++; if (bus.issued_cnt !== model_cnt) begin n_err++; $display("FAIL full_rate_cnt got=%0d exp=%0d", bus.issued_cnt, model_cnt); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL full_rate_idle got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        int base = n_drained;
        int pulses = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = (c < 3);
            if (c == 1) set_op(3'd7, 32'hBAD0_0000, 32'hBAD1_1111, 16'hBAD2, 5'd31);
            else        set_op(3'd0, 32'hA0 + 32'(c), 32'h5, 16'h0, 5'(c));
            if (bus.illegal_op === 1'b1) pulses++;
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL illegal_pulses got=%0d exp=1", pulses); end
        n_cmp++; if (n_drained - base != 2) begin n_err++; $display("FAIL illegal_issued got=%0d exp=2", n_drained - base); end
        n_cmp++; if (bus.issued_cnt !== model_cnt) begin n_err++; $display("FAIL illegal_cnt got=%0d exp=%0d", bus.issued_cnt, model_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        int base;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        set_op(3'd0, 32'h77, 32'h1, 16'h0, 5'd7);
        tick();
        set_op(3'd1, 32'h88, 32'h2, 16'h0, 5'd8);
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_full got=%b/%b exp=0/1", bus.in_ready, bus.out_valid);
        end
        hold_reset(1);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.issued_cnt !== 32'd0) begin n_err++; $display("FAIL mid_rst_cnt got=%0d exp=0", bus.issued_cnt); end
        bus.out_ready = 1'b1;
        release_reset();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_rst_after got=%b/%b exp=0/1", bus.out_valid, bus.in_ready);
        end
        base = n_drained;
        bus.in_valid = 1'b1;
        set_op(3'd4, 32'h99, 32'h3, 16'h0, 5'd9);
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if (n_drained - base != 1) begin n_err++; $display("FAIL mid_rst_new got=%0d exp=1", n_drained - base); end
        n_cmp++; if (bus.issued_cnt !== 32'd1) begin n_err++; $display("FAIL mid_rst_cnt_new got=%0d exp=1", bus.issued_cnt); end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_op(3'd0, 32'h0, 32'h0, 16'h0, 5'd0);
        test_reset();
        test_map();
        test_back_to_back();
        test_full_rate();
        test_illegal();
        test_reset_mid_stall();
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL final_pending got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
